stim_dac_spi: RTL and testbench

Downstream stage of the stimulation PID controller. It samples the controller's 16-bit unsigned `val_out` on a fixed update period and serializes it, with an 8-bit control prefix, as a 24-bit SPI frame to the stimulation-current DAC (DAC8551-style: SYNC-framed, MSB first, sampled on SCLK falling edge). It owns all DAC pin timing, so the PID core never sees the serial interface.

---
 rtl/stim_pkg.sv | 17 +
 rtl/stim_dac_spi_if.sv | 12 +
 rtl/stim_update_timer.sv | 33 +++
 rtl/stim_dac_spi.sv | 162 ++++++++++++++++
 tb/tb_stim_dac_spi.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/stim_pkg.sv
// Shared definitions for the stimulation datapath.
// Contents: DAC frame width, DAC control-byte encodings and the
// serializer state type.
package stim_pkg;

  localparam int unsigned DAC_FRAME_BITS  = 24;
  localparam logic [7:0]  DAC_CTRL_NORMAL = 8'h00;
  localparam logic [7:0]  DAC_CTRL_PD_1K  = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } dac_state_e;

endpackage

// File: rtl/stim_dac_spi_if.sv
// DAC serial pin bundle.
// Signals: dac_sclk (SPI clock, idles high), dac_sync_n (frame select,
// active low), dac_din (serial data, MSB first).
// The master modport drives the pins; the slave modport observes them.
interface stim_dac_spi_if;
  logic dac_sclk;
  logic dac_sync_n;
  logic dac_din;

  modport master (output dac_sclk, output dac_sync_n, output dac_din);
  modport slave  (input  dac_sclk, input  dac_sync_n, input  dac_din);
endinterface

// File: rtl/stim_update_timer.sv
// Free-running sample timer. Counts 0..UPDATE_PERIOD-1 while enabled and
// raises tick during the cycle the count sits at UPDATE_PERIOD-1.
// Ports: clk, rst_n (async, active low), enable (run / hold at 0),
// tick (one-cycle sample strobe).
module stim_update_timer #(
  parameter int unsigned UPDATE_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned   CW   = $clog2(UPDATE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(UPDATE_PERIOD - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!enable)               count_d = '0;
    else if (count_q == LAST)  count_d = '0;
    else                       count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/stim_dac_spi.sv
// Periodic DAC update serializer. Samples val_in on each timer tick and
// shifts {CTRL_BYTE, val_in} out as a 24-bit SYNC-framed SPI frame, MSB
// first, with the DAC sampling on SCLK falling edges.
// Ports: clk, rst_n (async, active low), enable (run update timer),
// val_in (16-bit DAC code), dac (serial pins, master side),
// busy (frame in progress), frame_done (pulse at frame end),
// overrun (pulse when a tick is dropped because a frame is in flight).
//
//   state | meaning
//   IDLE  | waiting for a tick; SCLK high, SYNC high
//   SETUP | SYNC low, MSB presented, SCLK held high for CLK_DIV cycles
//   SHIFT | 24 bits, each CLK_DIV low then CLK_DIV high
//   HOLD  | SYNC high, DIN low, SCLK high for CLK_DIV cycles
module stim_dac_spi
  import stim_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned UPDATE_PERIOD = 1000,
  parameter logic [7:0]  CTRL_BYTE     = DAC_CTRL_NORMAL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [15:0]           val_in,
  stim_dac_spi_if.master        dac,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam logic [7:0] PH_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(DAC_FRAME_BITS - 1);

  logic tick;

  stim_update_timer #(.UPDATE_PERIOD(UPDATE_PERIOD)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  dac_state_e  state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] shreg_q, shreg_d;
  logic        sclk_q, sclk_d;
  logic        sync_n_q, sync_n_d;
  logic        din_q, din_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        phase_end;

  assign phase_end = (phase_q == PH_LAST);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    din_d    = din_q;
    done_d   = 1'b0;
    ovr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          shreg_d  = {CTRL_BYTE, val_in};
          din_d    = CTRL_BYTE[7];
          sync_n_d = 1'b0;
          phase_d  = '0;
          bit_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      SHIFT: begin
        if (!phase_end) begin
          phase_d = phase_q + 8'd1;
        end else begin
          phase_d = '0;
          if (!sclk_q) begin
            // End of low phase: DIN moves on the rising edge, half a bit
            // away from the falling edges the DAC samples on.
            sclk_d = 1'b1;
            if (bit_q != BIT_LAST) begin
              din_d   = shreg_q[22];
              shreg_d = {shreg_q[22:0], 1'b0};
            end
          end else if (bit_q == BIT_LAST) begin
            sync_n_d = 1'b1;
            din_d    = 1'b0;
            state_d  = HOLD;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 5'd1;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          phase_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A tick outside IDLE is dropped; the frame in flight is untouched.
    if (tick && (state_q != IDLE)) ovr_d = 1'b1;
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      din_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dac.dac_sclk   = sclk_q;
  assign dac.dac_sync_n = sync_n_q;
  assign dac.dac_din    = din_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_stim_dac_spi.sv
// Directed bench for stim_dac_spi. Instance A uses UPDATE_PERIOD=200,
// instance B uses UPDATE_PERIOD=60 to force overruns; both CLK_DIV=2.
module tb_stim_dac_spi;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, en_a, en_b;
  logic [15:0] val_a, val_b;
  logic        busy_a, busy_b, fd_a, fd_b, ovr_a, ovr_b;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  stim_dac_spi_if spi_a ();
  stim_dac_spi_if spi_b ();

  stim_dac_spi #(.CLK_DIV(2), .UPDATE_PERIOD(200), .CTRL_BYTE(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_a), .enable(en_a), .val_in(val_a), .dac(spi_a),
    .busy(busy_a), .frame_done(fd_a), .overrun(ovr_a)
  );

  stim_dac_spi #(.CLK_DIV(2), .UPDATE_PERIOD(60), .CTRL_BYTE(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_b), .enable(en_b), .val_in(val_b), .dac(spi_b),
    .busy(busy_b), .frame_done(fd_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic sclk_s [2];
  logic sync_s [2];
  logic din_s  [2];
  logic busy_s [2];
  logic fd_s   [2];
  logic ovr_s  [2];
  assign sclk_s[0] = spi_a.dac_sclk;   assign sclk_s[1] = spi_b.dac_sclk;
  assign sync_s[0] = spi_a.dac_sync_n; assign sync_s[1] = spi_b.dac_sync_n;
  assign din_s[0]  = spi_a.dac_din;    assign din_s[1]  = spi_b.dac_din;
  assign busy_s[0] = busy_a;           assign busy_s[1] = busy_b;
  assign fd_s[0]   = fd_a;             assign fd_s[1]   = fd_b;
  assign ovr_s[0]  = ovr_a;            assign ovr_s[1]  = ovr_b;

  // Pin-level DAC model: shifts DIN on each SCLK fall while SYNC is low,
  // latches the collected word when SYNC rises.
  logic        prev_sclk [2] = '{1'b1, 1'b1};
  logic        prev_sync [2] = '{1'b1, 1'b1};
  logic [23:0] word_c    [2] = '{24'h0, 24'h0};
  logic [23:0] last_word [2] = '{24'h0, 24'h0};
  int          bits_c    [2] = '{0, 0};
  int          last_bits [2] = '{0, 0};
  int          low_c     [2] = '{0, 0};
  int          last_low  [2] = '{0, 0};
  int          nfall     [2] = '{0, 0};
  int          novr      [2] = '{0, 0};

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (prev_sync[m] === 1'b1 && sync_s[m] === 1'b0) begin
        nfall[m]  <= nfall[m] + 1;
        bits_c[m] <= 0;
        word_c[m] <= 24'h0;
        low_c[m]  <= 1;
      end else if (sync_s[m] === 1'b0) begin
        low_c[m] <= low_c[m] + 1;
        if (prev_sclk[m] === 1'b1 && sclk_s[m] === 1'b0) begin
          word_c[m] <= {word_c[m][22:0], din_s[m]};
          bits_c[m] <= bits_c[m] + 1;
        end
      end
      if (prev_sync[m] === 1'b0 && sync_s[m] === 1'b1) begin
        last_word[m] <= word_c[m];
        last_bits[m] <= bits_c[m];
        last_low[m]  <= low_c[m];
      end
      if (ovr_s[m] === 1'b1) novr[m] <= novr[m] + 1;
      prev_sclk[m] <= sclk_s[m];
      prev_sync[m] <= sync_s[m];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind 0: SYNC low, 1: frame_done, 2: overrun, 3: bits shifted >= thr
  task automatic wait_ev(input int kind, input int m, input int thr, input int budget,
                         input string tag, output int t);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (kind)
        0:       hit = (sync_s[m] === 1'b0);
        1:       hit = (fd_s[m] === 1'b1);
        2:       hit = (ovr_s[m] === 1'b1);
        default: hit = (bits_c[m] >= thr);
      endcase
    end
    t = cyc;
    check({tag, "_seen"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t_en, t_s, t_s2, t_d, t_o, t_prev, t_r, nf;
    logic [15:0] vb [4];
    vb = '{16'h1357, 16'h2468, 16'h9ABC, 16'hF00D};

    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    val_a = 16'h0; val_b = 16'h0;
    repeat (3) step();
    rst_a = 1'b1; rst_b = 1'b1;

    // Idle after reset: pins parked, no pulses.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("reset_idle", {26'd0, sclk_s[0], sync_s[0], din_s[0], busy_s[0], fd_s[0], ovr_s[0]},
            32'b110000);
    end

    // Basic frame, val 0xA5C3.
    step();
    val_a = 16'hA5C3; en_a = 1'b1; t_en = cyc;
    wait_ev(0, 0, 0, 300, "first_sync", t_s);
    check("first_tick_latency", t_s - t_en, 200);
    check("busy_rise", {31'd0, busy_s[0]}, 1);
    check("sclk_high_at_sync", {31'd0, sclk_s[0]}, 1);
    check("din_msb", {31'd0, din_s[0]}, 0);
    wait_ev(1, 0, 0, 200, "done_a1", t_d);
    check("done_latency", t_d - t_s, 100);
    check("busy_fall_with_done", {31'd0, busy_s[0]}, 0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, fd_s[0]}, 0);
    check("frame_a5c3", {8'd0, last_word[0]}, 32'h00A5C3);
    check("bits_a5c3", last_bits[0], 24);
    check("sync_low_len", last_low[0], 98);

    // val_in change mid-frame only affects the next frame.
    step();
    val_a = 16'h0000;
    wait_ev(0, 0, 0, 300, "sync_2", t_s2);
    check("update_period", t_s2 - t_s, 200);
    repeat (10) step();
    val_a = 16'hFFFF;
    wait_ev(1, 0, 0, 200, "done_2", t_d);
    check("frame_inflight_0000", {8'd0, last_word[0]}, 32'h000000);
    wait_ev(0, 0, 0, 300, "sync_3", t_s);
    wait_ev(1, 0, 0, 200, "done_3", t_d);
    check("frame_next_ffff", {8'd0, last_word[0]}, 32'h00FFFF);

    // Drop enable at bit 10: frame completes, nothing follows.
    step();
    val_a = 16'h1234;
    wait_ev(0, 0, 0, 300, "sync_4", t_s);
    wait_ev(3, 0, 10, 200, "bit10", t_o);
    step();
    en_a = 1'b0;
    wait_ev(1, 0, 0, 200, "done_4", t_d);
    @(negedge clk);
    check("frame_1234", {8'd0, last_word[0]}, 32'h001234);
    check("bits_1234", last_bits[0], 24);
    nf = nfall[0];
    repeat (600) @(negedge clk);
    check("no_sync_after_disable", nfall[0], nf);
    check("idle_after_disable", {30'd0, sync_s[0], busy_s[0]}, 32'b10);

    // Reset at bit 12.
    step();
    val_a = 16'hBEEF; en_a = 1'b1;
    wait_ev(0, 0, 0, 300, "sync_5", t_s);
    wait_ev(3, 0, 12, 200, "bit12", t_o);
    #1 rst_a = 1'b0;
    #1;
    check("rst_sync_high", {31'd0, sync_s[0]}, 1);
    check("rst_busy_low", {31'd0, busy_s[0]}, 0);
    check("rst_sclk_high", {31'd0, sclk_s[0]}, 1);
    repeat (2) step();
    rst_a = 1'b1; t_r = cyc;
    @(negedge clk);
    check("aborted_bits", last_bits[0], 12);
    wait_ev(0, 0, 0, 300, "sync_post_rst", t_s);
    check("post_rst_latency", t_s - t_r, 200);
    wait_ev(1, 0, 0, 200, "done_post_rst", t_d);
    @(negedge clk);
    check("frame_beef", {8'd0, last_word[0]}, 32'h00BEEF);
    check("bits_beef", last_bits[0], 24);
    check("sync_low_beef", last_low[0], 98);
    step();
    en_a = 1'b0;

    // Overrun: period 60, frame 101 cycles.
    step();
    val_b = vb[0]; en_b = 1'b1; t_en = cyc; t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ev(0, 1, 0, 300, "b_sync", t_s);
      if (i == 0) check("b_first_latency", t_s - t_en, 60);
      else        check("b_frame_spacing", t_s - t_prev, 120);
      t_prev = t_s;
      step();
      val_b = 16'hDEAD;
      wait_ev(2, 1, 0, 100, "b_ovr", t_o);
      check("b_ovr_timing", t_o - t_s, 60);
      step();
      val_b = (i < 3) ? vb[(i + 1) % 4] : 16'h0000;
      wait_ev(1, 1, 0, 100, "b_done", t_d);
      check("b_done_timing", t_d - t_s, 100);
      @(negedge clk);
      check("b_frame_word", {8'd0, last_word[1]}, {16'd0, vb[i]});
    end
    step();
    en_b = 1'b0;
    repeat (5) @(negedge clk);
    check("b_total_overruns", novr[1], 4);
    check("b_total_frames", nfall[1], 4);
    check("a_no_overrun", novr[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
